// File: rtl/ball_ctrl.sv
// Ball motion and collision engine for the brick breaker game.
// The ball is parked on the paddle until a serve. After that it moves one
// pixel diagonally every STEP_DIV clocks and bounces off the walls, the paddle
// and bricks. When the ball is lost, the engine counts down the lives.
// Handshake: there is none. brick_hit is a one-cycle strobe that is sampled
// on every clock while the game is in play. miss is a one-cycle strobe that
// is registered and rises on the clock after the step that lost the ball.
// o_dbg_state exposes the FSM state (0 idle, 1 play, 2 over) for observers.
module ball_ctrl #(
    parameter int STEP_DIV = 250000,
    parameter int X_MIN    = 134,
    parameter int X_MAX    = 506,
    parameter int Y_MIN    = 40,
    parameter int Y_MAX    = 479,
    parameter int PADDLE_Y = 420,
    parameter int PADDLE_W = 62,
    parameter int BALL_SZ  = 8,
    parameter int LIVES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       serve,
    input  logic [8:0] paddle_x,
    input  logic       brick_hit,
    output logic [8:0] ball_x,
    output logic [8:0] ball_y,
    output logic [1:0] lives,
    output logic       miss,
    output logic       game_over,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    // Every position compare is done 10 bits wide so that no sum can wrap.
    localparam logic [9:0] L_XMIN = 10'(X_MIN);
    localparam logic [9:0] L_XMAX = 10'(X_MAX);
    localparam logic [9:0] L_YMIN = 10'(Y_MIN);
    localparam logic [9:0] L_YMAX = 10'(Y_MAX);
    localparam logic [9:0] L_PY   = 10'(PADDLE_Y);
    localparam logic [9:0] L_PW   = 10'(PADDLE_W);
    localparam logic [9:0] L_BSZ  = 10'(BALL_SZ);
    localparam logic [8:0] PARK_DX = 9'((PADDLE_W - BALL_SZ) / 2);
    localparam logic [8:0] PARK_Y  = 9'(PADDLE_Y - BALL_SZ);
    localparam logic [8:0] RST_X   = 9'd317;
    localparam logic [1:0] L_LIVES = 2'(LIVES);

    // Direction flags: 1 means moving toward smaller coordinates.
    state_t           r_state,  w_state_nxt;
    logic [8:0]       r_ball_x, w_ball_x_nxt;
    logic [8:0]       r_ball_y, w_ball_y_nxt;
    logic             r_dx_neg, w_dx_neg_nxt;
    logic             r_dy_neg, w_dy_neg_nxt;
    logic [1:0]       r_lives,  w_lives_nxt;
    logic             r_miss,   w_miss_nxt;
    logic             r_over,   w_over_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic             r_pend,   w_pend_nxt;

    logic [9:0] w_bx10, w_by10, w_px10;
    logic       w_dy_e_neg;
    logic       w_x_block;
    logic       w_top_hit;
    logic       w_pad_hit;
    logic       w_bottom;

    // Collision predicates, evaluated on the current position and directions.
    always_comb begin
        w_bx10     = {1'b0, r_ball_x};
        w_by10     = {1'b0, r_ball_y};
        w_px10     = {1'b0, paddle_x};
        w_dy_e_neg = r_pend ? ~r_dy_neg : r_dy_neg;
        if (r_dx_neg) begin
            w_x_block = (w_bx10 < L_XMIN + 10'd1) ||
                        (w_bx10 + L_BSZ - 10'd1 > L_XMAX);
        end else begin
            w_x_block = (w_bx10 + 10'd1 < L_XMIN) ||
                        (w_bx10 + 10'd1 + L_BSZ > L_XMAX);
        end
        w_top_hit = w_dy_e_neg && (w_by10 < L_YMIN + 10'd1);
        w_pad_hit = !w_dy_e_neg && (w_by10 + L_BSZ == L_PY) &&
                    (w_bx10 + L_BSZ > w_px10) && (w_bx10 < w_px10 + L_PW);
        w_bottom  = !w_dy_e_neg && (w_by10 + 10'd1 + L_BSZ >= L_YMAX);
    end

    // Next-state logic: parking, the step timer, movement and loss of the ball.
    always_comb begin
        w_state_nxt  = r_state;
        w_ball_x_nxt = r_ball_x;
        w_ball_y_nxt = r_ball_y;
        w_dx_neg_nxt = r_dx_neg;
        w_dy_neg_nxt = r_dy_neg;
        w_lives_nxt  = r_lives;
        w_miss_nxt   = 1'b0;
        w_over_nxt   = r_over;
        w_cnt_nxt    = r_cnt;
        w_pend_nxt   = r_pend;
        case (r_state)
            S_IDLE: begin
                w_ball_x_nxt = paddle_x + PARK_DX;
                w_ball_y_nxt = PARK_Y;
                w_cnt_nxt    = '0;
                w_pend_nxt   = 1'b0;
                if (start && !serve) begin
                    w_state_nxt  = S_PLAY;
                    w_dx_neg_nxt = 1'b0;
                    w_dy_neg_nxt = 1'b1;
                end
            end
            S_PLAY: begin
                if (start && (r_cnt == CNT_LAST)) begin
                    w_cnt_nxt = '0;
                    // The step consumes the pending brick. A strobe that
                    // arrives in this same cycle is kept for the next step.
                    w_pend_nxt = brick_hit;
                    if (w_x_block) begin
                        w_dx_neg_nxt = ~r_dx_neg;
                    end else begin
                        w_ball_x_nxt = r_dx_neg ? (r_ball_x - 9'd1) : (r_ball_x + 9'd1);
                    end
                    if (w_top_hit) begin
                        w_dy_neg_nxt = 1'b0;
                    end else if (w_pad_hit) begin
                        w_dy_neg_nxt = 1'b1;
                    end else if (w_bottom) begin
                        w_miss_nxt  = 1'b1;
                        w_lives_nxt = r_lives - 2'd1;
                        w_pend_nxt  = 1'b0;
                        if (r_lives == 2'd1) begin
                            w_state_nxt = S_OVER;
                            w_over_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_dy_neg_nxt = w_dy_e_neg;
                        w_ball_y_nxt = w_dy_e_neg ? (r_ball_y - 9'd1) : (r_ball_y + 9'd1);
                    end
                end else begin
                    if (start) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                    w_pend_nxt = r_pend | brick_hit;
                end
            end
            S_OVER: begin
                w_over_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register with an asynchronous, active-low reset to the parked serve position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_ball_x <= RST_X;
            r_ball_y <= PARK_Y;
            r_dx_neg <= 1'b0;
            r_dy_neg <= 1'b1;
            r_lives  <= L_LIVES;
            r_miss   <= 1'b0;
            r_over   <= 1'b0;
            r_cnt    <= '0;
            r_pend   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ball_x <= w_ball_x_nxt;
            r_ball_y <= w_ball_y_nxt;
            r_dx_neg <= w_dx_neg_nxt;
            r_dy_neg <= w_dy_neg_nxt;
            r_lives  <= w_lives_nxt;
            r_miss   <= w_miss_nxt;
            r_over   <= w_over_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pend   <= w_pend_nxt;
        end
    end

    assign ball_x      = r_ball_x;
    assign ball_y      = r_ball_y;
    assign lives       = r_lives;
    assign miss        = r_miss;
    assign game_over   = r_over;
    assign o_dbg_state = r_state;

endmodule

// File: doc/ball_ctrl.md
Name: ball_ctrl

Overview:
- Ball motion and collision engine for brick breaker; directly downstream of the paddle position register, consuming its 9-bit paddle x each cycle.
- Parks the ball on the paddle until serve, then steps it diagonally at a fixed tick rate.
- Bounces off side/top walls, the paddle and bricks.
- Detects misses, counts lives, flags game over.
- Outputs ball position to the renderer and brick logic.

Parameters:
- STEP_DIV, 250000: clocks per ball step (use 4 in simulation)
- X_MIN, 134: left wall, first legal ball x
- X_MAX, 506: right wall, ball_x+BALL_SZ must stay <= X_MAX
- Y_MIN, 40: top wall, first legal ball y
- Y_MAX, 479: bottom; ball_y+BALL_SZ >= Y_MAX is a miss
- PADDLE_Y, 420: top row of paddle
- PADDLE_W, 62: paddle width
- BALL_SZ, 8: ball edge length
- LIVES, 3: lives at reset

Ports:
- clk, in, 1: system clock
- rst, in, 1: asynchronous, active-low reset
- start, in, 1: game running level; 0 freezes all motion
- serve, in, 1: serve button, active-low
- paddle_x, in, 9: paddle left edge
- brick_hit, in, 1: one-cycle pulse from brick array, ball touched a brick
- ball_x, out, 9: ball left edge
- ball_y, out, 9: ball top edge
- lives, out, 2: remaining lives
- miss, out, 1: one-cycle pulse on ball loss
- game_over, out, 1: high once lives reach 0

Behaviour:
- Reset values:
  - state=IDLE, ball_x=317, ball_y=PADDLE_Y-BALL_SZ (412)
  - dx=+1, dy=-1 (up), lives=LIVES, miss=0, game_over=0
  - step counter=0, brick pending flag=0
- Arithmetic: all position compares use 10-bit zero-extended sums; no wrap.
- IDLE:
  - Every cycle: ball_x <= paddle_x+(PADDLE_W-BALL_SZ)/2 (i.e. +27), ball_y <= PADDLE_Y-BALL_SZ.
  - When start=1 and serve=0: go to PLAY, dx=+1, dy=-1, counter=0.
- PLAY, step counter:
  - start=0: counter and position hold; no state change.
  - start=1: counter increments; on reaching STEP_DIV-1 it clears and one step executes in that cycle.
- PLAY, brick_hit:
  - Sets the pending flag in any PLAY cycle.
  - Consumed (cleared) at the next step.
  - Multiple pulses between steps count once.
  - Ignored outside PLAY.
- Step evaluation, in order:
  1. dy_e = pending ? -dy : dy
  2. X: if ball_x+dx < X_MIN or ball_x+dx+BALL_SZ > X_MAX, dx <= -dx and ball_x unchanged; else ball_x <= ball_x+dx.
  3. Y, top: dy_e=-1 and ball_y-1 < Y_MIN: dy <= +1, ball_y unchanged.
  4. Y, paddle: dy_e=+1, ball_y+BALL_SZ == PADDLE_Y, ball_x+BALL_SZ > paddle_x, ball_x < paddle_x+PADDLE_W: dy <= -1, ball_y unchanged.
  5. Y, miss: dy_e=+1, ball_y+1+BALL_SZ >= Y_MAX: miss event.
  6. Otherwise: dy <= dy_e, ball_y <= ball_y+dy_e.
- X and Y rules are independent: a corner hit reverses both.
- Paddle rule overrides a pending brick reversal (dy_e already computed).
- Miss event:
  - miss=1 for exactly one cycle; lives <= lives-1.
  - Previous lives==1: go to OVER, game_over=1.
  - Otherwise: go to IDLE, ball re-parks next cycle; pending flag cleared.
- OVER:
  - Ball frozen; all inputs ignored; game_over held at 1 until rst.
- rst low mid-step or mid-game: immediate return to reset values, no miss pulse.
- lives never underflows: the OVER transition happens before 0 is decremented.

Test Plan:
- Reset, paddle_x=290 -> ball=(317,412), lives=3, IDLE; paddle_x=200 -> ball_x=227 next cycle.
- STEP_DIV=4, start=1, serve pulsed low at (317,412) -> PLAY; after 4 clocks ball=(318,411), then one step per 4 clocks.
- Ball at x=498 moving right (498+1+8>506) -> dx=-1, x stays 498; next step x=497.
- Ball falling to y=412, ball_x=300, paddle_x=290 -> dy=-1, y stays 412; same with paddle_x=100 -> continues, miss pulse at bottom, lives 3->2, IDLE.
- Two brick_hit pulses between steps while moving up -> exactly one reversal (dy=+1); start=0 for 20 clocks mid-flight -> position and counter frozen.
- Lose 3 balls -> third miss asserts game_over=1, lives=0; serve ignored; rst low -> full reset values.
